branch_predictor: RTL and testbench

Dynamic branch predictor for the five-stage pipeline. Looks up the IF-stage PC in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. In the same cycle it produces `jump_guess_if` and the predicted target consumed by the PC-select logic. Trains on resolved branch/jump outcomes from EX, and keeps branch and misprediction statistics counters for the debug bus.

---
 rtl/bp_pkg.sv | 18 +
 rtl/bp_sat_ctr2.sv | 22 ++
 rtl/branch_predictor.sv | 107 ++++++++++
 tb/tb_branch_predictor.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the dynamic branch predictor: 2-bit counter
// encodings, default table geometry and counter initial values.
package bp_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    localparam int DEFAULT_IDX_W = 4;

    // New entries start weakly taken so one not-taken outcome flips them.
    localparam logic [1:0] CTR_ALLOC = CTR_WT;
    localparam logic [1:0] CTR_RESET = CTR_WNT;

endpackage

// File: rtl/bp_sat_ctr2.sv
// Next-state logic for one 2-bit saturating direction counter.
module bp_sat_ctr2
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_nxt
);

    // Saturating step toward the resolved outcome.
    always_comb begin
        ctr_nxt = ctr;
        case (ctr)
            CTR_SNT: ctr_nxt = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: ctr_nxt = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  ctr_nxt = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  ctr_nxt = taken ? CTR_ST  : CTR_WT;
            default: ctr_nxt = ctr;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational IF-stage lookup,
// EX-stage training and branch/misprediction statistics.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int IDX_W = DEFAULT_IDX_W,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_if,
    output logic            jump_guess_if,
    output logic [XLEN-1:0] pred_target_if,
    input  logic            upd_en_ex,
    input  logic [XLEN-1:0] pc_ex,
    input  logic            jump_ex,
    input  logic [XLEN-1:0] target_ex,
    input  logic            jump_guess_ex,
    output logic [31:0]     br_cnt,
    output logic [31:0]     miss_cnt
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = XLEN - IDX_W - 2;

    // Register arrays so the lookup read is asynchronous.
    logic             valid_r  [ENTRIES];
    logic [TAG_W-1:0] tag_r    [ENTRIES];
    logic [XLEN-1:0]  target_r [ENTRIES];
    logic [1:0]       ctr_r    [ENTRIES];
    logic [31:0]      br_cnt_r;
    logic [31:0]      miss_cnt_r;

    logic [IDX_W-1:0] look_idx_s;
    logic [TAG_W-1:0] look_tag_s;
    logic             look_hit_s;
    logic [IDX_W-1:0] upd_idx_s;
    logic [TAG_W-1:0] upd_tag_s;
    logic             upd_hit_s;
    logic [1:0]       ctr_nxt_s;
    logic             unused_s;

    assign look_idx_s = pc_if[IDX_W+1:2];
    assign look_tag_s = pc_if[XLEN-1:IDX_W+2];
    assign look_hit_s = valid_r[look_idx_s] && (tag_r[look_idx_s] == look_tag_s);

    assign upd_idx_s  = pc_ex[IDX_W+1:2];
    assign upd_tag_s  = pc_ex[XLEN-1:IDX_W+2];
    assign upd_hit_s  = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);

    // Instructions are word aligned; the low PC bits carry no information.
    assign unused_s   = ^{pc_if[1:0], pc_ex[1:0]};

    bp_sat_ctr2 u_sat_ctr (
        .ctr     (ctr_r[upd_idx_s]),
        .taken   (jump_ex),
        .ctr_nxt (ctr_nxt_s)
    );

    // Lookup reads pre-update contents; there is no bypass from the EX port.
    always_comb begin
        jump_guess_if  = 1'b0;
        pred_target_if = {XLEN{1'b0}};
        if (look_hit_s && ctr_r[look_idx_s][1]) begin
            jump_guess_if  = 1'b1;
            pred_target_if = target_r[look_idx_s];
        end else begin
            jump_guess_if  = 1'b0;
            pred_target_if = {XLEN{1'b0}};
        end
    end

    // Table training and statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= {TAG_W{1'b0}};
                target_r[i] <= {XLEN{1'b0}};
                ctr_r[i]    <= CTR_RESET;
            end
            br_cnt_r   <= 32'd0;
            miss_cnt_r <= 32'd0;
        end else if (upd_en_ex) begin
            br_cnt_r <= br_cnt_r + 32'd1;
            // A wrong target on a correctly guessed taken branch is not a miss.
            if (jump_guess_ex != jump_ex) begin
                miss_cnt_r <= miss_cnt_r + 32'd1;
            end
            if (upd_hit_s) begin
                ctr_r[upd_idx_s] <= ctr_nxt_s;
                if (jump_ex) begin
                    target_r[upd_idx_s] <= target_ex;
                end
            end else if (jump_ex) begin
                valid_r[upd_idx_s]  <= 1'b1;
                tag_r[upd_idx_s]    <= upd_tag_s;
                target_r[upd_idx_s] <= target_ex;
                ctr_r[upd_idx_s]    <= CTR_ALLOC;
            end
        end
    end

    assign br_cnt   = br_cnt_r;
    assign miss_cnt = miss_cnt_r;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: hand-computed vector table,
// multi-cycle corner sequences and randomized traffic against a reference model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_if;
    logic        jump_guess_if;
    logic [31:0] pred_target_if;
    logic        upd_en_ex;
    logic [31:0] pc_ex;
    logic        jump_ex;
    logic [31:0] target_ex;
    logic        jump_guess_ex;
    logic [31:0] br_cnt;
    logic [31:0] miss_cnt;

    int total = 0;
    int bad   = 0;

    branch_predictor dut (
        .clk            (clk),
        .rst            (rst),
        .pc_if          (pc_if),
        .jump_guess_if  (jump_guess_if),
        .pred_target_if (pred_target_if),
        .upd_en_ex      (upd_en_ex),
        .pc_ex          (pc_ex),
        .jump_ex        (jump_ex),
        .target_ex      (target_ex),
        .jump_guess_ex  (jump_guess_ex),
        .br_cnt         (br_cnt),
        .miss_cnt       (miss_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: a plain table of 16 slots with integer counters 0..3.
    logic        m_valid  [16];
    logic [25:0] m_tag    [16];
    logic [31:0] m_target [16];
    int          m_ctr    [16];
    int unsigned m_br;
    int unsigned m_miss;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = '0; m_target[i] = '0; m_ctr[i] = 1;
        end
        m_br = 0; m_miss = 0;
    endfunction

    function automatic logic model_guess(input logic [31:0] pc);
        int i = int'(pc[5:2]);
        return m_valid[i] && m_tag[i] == pc[31:6] && m_ctr[i] >= 2;
    endfunction

    function automatic logic [31:0] model_target(input logic [31:0] pc);
        return model_guess(pc) ? m_target[int'(pc[5:2])] : 32'd0;
    endfunction

    function automatic void model_update(input logic [31:0] pc, input logic taken,
                                         input logic [31:0] tgt, input logic guess);
        int i = int'(pc[5:2]);
        m_br++;
        if (guess != taken) m_miss++;
        if (m_valid[i] && m_tag[i] == pc[31:6]) begin
            if (taken) begin
                m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                m_target[i] = tgt;
            end else begin
                m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end
        end else if (taken) begin
            m_valid[i] = 1'b1; m_tag[i] = pc[31:6]; m_target[i] = tgt; m_ctr[i] = 2;
        end
    endfunction

    typedef struct {
        logic        upd;
        logic [31:0] pc;
        logic        jump;
        logic [31:0] tgt;
        logic        guess;
        logic [31:0] look;
        logic        exp_guess;
        logic [31:0] exp_tgt;
        logic [31:0] exp_br;
        logic [31:0] exp_miss;
    } vec_t;

    vec_t vecs [14];

    initial begin
        // Starts right after 0x40 was allocated (WT, target 0x100), br=1 miss=1.
        vecs[0]  = '{1'b1, 32'h40, 1'b0, 32'h0,   1'b1, 32'h40, 1'b0, 32'h0,   32'd2,  32'd2};
        vecs[1]  = '{1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h40, 1'b1, 32'h100, 32'd3,  32'd3};
        vecs[2]  = '{1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h40, 1'b1, 32'h100, 32'd4,  32'd3};
        vecs[3]  = '{1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h40, 1'b1, 32'h100, 32'd5,  32'd3};
        vecs[4]  = '{1'b1, 32'h40, 1'b1, 32'h104, 1'b1, 32'h40, 1'b1, 32'h104, 32'd6,  32'd3};
        vecs[5]  = '{1'b1, 32'h40, 1'b0, 32'h0,   1'b1, 32'h40, 1'b1, 32'h104, 32'd7,  32'd4};
        vecs[6]  = '{1'b1, 32'h80, 1'b1, 32'h200, 1'b0, 32'h40, 1'b0, 32'h0,   32'd8,  32'd5};
        vecs[7]  = '{1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h80, 1'b1, 32'h200, 32'd8,  32'd5};
        vecs[8]  = '{1'b1, 32'hC0, 1'b0, 32'h0,   1'b0, 32'h80, 1'b1, 32'h200, 32'd9,  32'd5};
        vecs[9]  = '{1'b1, 32'hC0, 1'b0, 32'h0,   1'b0, 32'hC0, 1'b0, 32'h0,   32'd10, 32'd5};
        vecs[10] = '{1'b1, 32'h44, 1'b0, 32'h0,   1'b0, 32'h44, 1'b0, 32'h0,   32'd11, 32'd5};
        vecs[11] = '{1'b1, 32'h80, 1'b0, 32'h0,   1'b1, 32'h80, 1'b0, 32'h0,   32'd12, 32'd6};
        vecs[12] = '{1'b1, 32'h84, 1'b1, 32'h300, 1'b0, 32'h84, 1'b1, 32'h300, 32'd13, 32'd7};
        vecs[13] = '{1'b0, 32'h48, 1'b1, 32'h999, 1'b1, 32'h48, 1'b0, 32'h0,   32'd13, 32'd7};

        rst = 1'b1; pc_if = 32'h40; upd_en_ex = 1'b0; pc_ex = '0;
        jump_ex = 1'b0; target_ex = '0; jump_guess_ex = 1'b0;
        #3;
        check("reset guess", {31'd0, jump_guess_if}, 32'd0);
        check("reset target", pred_target_if, 32'd0);
        #9 rst = 1'b0;
        @(posedge clk); #1;
        check("post-reset guess", {31'd0, jump_guess_if}, 32'd0);
        check("post-reset target", pred_target_if, 32'd0);
        check("post-reset br", br_cnt, 32'd0);
        check("post-reset miss", miss_cnt, 32'd0);

        // Cold miss, taken, with a lookup of the same PC in the update cycle.
        upd_en_ex = 1'b1; pc_ex = 32'h40; jump_ex = 1'b1; target_ex = 32'h100;
        jump_guess_ex = 1'b0; pc_if = 32'h40;
        #1;
        check("same-cycle guess", {31'd0, jump_guess_if}, 32'd0);
        @(posedge clk); #1;
        upd_en_ex = 1'b0;
        #1;
        check("alloc guess", {31'd0, jump_guess_if}, 32'd1);
        check("alloc target", pred_target_if, 32'h100);
        check("alloc br", br_cnt, 32'd1);
        check("alloc miss", miss_cnt, 32'd1);

        for (int i = 0; i < 14; i++) begin
            upd_en_ex = vecs[i].upd; pc_ex = vecs[i].pc; jump_ex = vecs[i].jump;
            target_ex = vecs[i].tgt; jump_guess_ex = vecs[i].guess;
            @(posedge clk); #1;
            upd_en_ex = 1'b0; pc_if = vecs[i].look;
            #1;
            check($sformatf("vec%0d guess", i), {31'd0, jump_guess_if}, {31'd0, vecs[i].exp_guess});
            check($sformatf("vec%0d target", i), pred_target_if, vecs[i].exp_tgt);
            check($sformatf("vec%0d br", i), br_cnt, vecs[i].exp_br);
            check($sformatf("vec%0d miss", i), miss_cnt, vecs[i].exp_miss);
        end

        // Asynchronous reset between edges with several valid entries.
        pc_if = 32'h84;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("async rst guess 0x84", {31'd0, jump_guess_if}, 32'd0);
        check("async rst target", pred_target_if, 32'd0);
        check("async rst br", br_cnt, 32'd0);
        check("async rst miss", miss_cnt, 32'd0);
        pc_if = 32'h40;
        #1;
        check("async rst guess 0x40", {31'd0, jump_guess_if}, 32'd0);
        upd_en_ex = 1'b1; pc_ex = 32'h40; jump_ex = 1'b1; target_ex = 32'h500; jump_guess_ex = 1'b0;
        @(posedge clk); #1;
        check("upd in rst guess", {31'd0, jump_guess_if}, 32'd0);
        check("upd in rst br", br_cnt, 32'd0);
        check("upd in rst miss", miss_cnt, 32'd0);
        upd_en_ex = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        check("after rst guess", {31'd0, jump_guess_if}, 32'd0);
        check("after rst br", br_cnt, 32'd0);

        // Randomized traffic over a small address space to force aliasing.
        model_reset();
        for (int n = 0; n < 600; n++) begin
            logic [31:0] pe;
            pe = {24'd0, 2'(n % 3 == 0 ? 0 : $urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
            pc_if = {24'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
            upd_en_ex = ($urandom_range(0, 3) != 0);
            pc_ex = pe;
            jump_ex = 1'($urandom_range(0, 1));
            target_ex = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
            jump_guess_ex = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : model_guess(pe);
            #2;
            check("rand guess", {31'd0, jump_guess_if}, {31'd0, model_guess(pc_if)});
            check("rand target", pred_target_if, model_target(pc_if));
            @(posedge clk);
            if (upd_en_ex) model_update(pc_ex, jump_ex, target_ex, jump_guess_ex);
            #1;
            check("rand br", br_cnt, m_br);
            check("rand miss", miss_cnt, m_miss);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
